// File: rtl/coeff_bank_ctrl.sv
// Multi-band FIR coefficient store: host-writable staging bank plus an active shadow bank.
// A commit copies the whole staging bank into the shadow bank in a single edge.
module coeff_bank_ctrl #(
    parameter int  COEFF_W     = 16,
    parameter int  TAPS        = 64,
    parameter int  BANDS       = 8,
    parameter int  SYNC_COMMIT = 1,
    localparam int ADDR_W      = $clog2(TAPS),
    localparam int BAND_W      = (BANDS > 1) ? $clog2(BANDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_enable,
    input  logic [ADDR_W-1:0]        current_count,
    input  logic                     write_enable,
    input  logic [BAND_W-1:0]        write_band,
    input  logic [ADDR_W-1:0]        write_address,
    input  logic [COEFF_W-1:0]       coeffs_in,
    input  logic                     commit_req,
    output logic                     commit_pending,
    output logic                     commit_done,
    input  logic [BAND_W-1:0]        rd_band,
    input  logic [ADDR_W-1:0]        rd_address,
    output logic [COEFF_W-1:0]       rd_data,
    output logic [BANDS*COEFF_W-1:0] coeffs_out
);

    logic                 r_pending;
    logic                 r_done;
    logic [COEFF_W-1:0]   r_rd_data;
    logic                 w_commit_window;
    logic                 w_commit;
    logic                 w_wr_valid;
    logic [COEFF_W-1:0]   w_rd_term [BANDS];
    logic [COEFF_W-1:0]   w_rd_mux;

    // Frame-boundary mode waits for the last tap of an enabled frame so no frame mixes banks.
    generate
        if (SYNC_COMMIT != 0) begin : g_sync_commit
            assign w_commit_window = clk_enable && (current_count == ADDR_W'(TAPS - 1));
        end else begin : g_imm_commit
            assign w_commit_window = 1'b1;
        end
    endgenerate

    assign w_commit   = r_pending && w_commit_window;
    assign w_wr_valid = clk_enable && write_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pending <= commit_req || (r_pending && !w_commit);
            r_done    <= w_commit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BANDS; gi++) begin : g_band
            logic [COEFF_W-1:0] r_staging [TAPS];
            logic [COEFF_W-1:0] r_shadow  [TAPS];
            logic [COEFF_W-1:0] r_coeff;
            logic               w_wr_hit;

            // Out-of-range band indices match no generated band, so such writes vanish.
            assign w_wr_hit = w_wr_valid && (write_band == BAND_W'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int t = 0; t < TAPS; t++) begin
                        r_staging[t] <= '0;
                        r_shadow[t]  <= '0;
                    end
                    r_coeff <= '0;
                end else begin
                    if (w_wr_hit) begin
                        r_staging[write_address] <= coeffs_in;
                    end
                    // Shadow samples staging before a same-edge write lands.
                    if (w_commit) begin
                        for (int t = 0; t < TAPS; t++) begin
                            r_shadow[t] <= r_staging[t];
                        end
                    end
                    if (clk_enable) begin
                        r_coeff <= r_shadow[current_count];
                    end
                end
            end

            assign w_rd_term[gi] = (rd_band == BAND_W'(gi)) ? r_staging[rd_address] : '0;
            assign coeffs_out[gi*COEFF_W +: COEFF_W] = r_coeff;
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int b = 0; b < BANDS; b++) begin
            w_rd_mux = w_rd_mux | w_rd_term[b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign commit_pending = r_pending;
    assign commit_done    = r_done;
    assign rd_data        = r_rd_data;

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// Bench for coeff_bank_ctrl: a frame-synchronous instance (8 bands x 64 taps) and an immediate-commit
// instance (6 bands x 8 taps) share one stimulus stream and are compared against a bank-level model.
module tb_coeff_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        ce = 1'b0, we = 1'b0, req = 1'b0;
    logic [2:0]  wb = '0, rdb = '0;
    logic [5:0]  wa = '0, rda = '0, cnt = '0;
    logic [15:0] din = '0;

    logic [127:0] a_out;
    logic [15:0]  a_rd;
    logic         a_pend, a_done;
    logic [95:0]  b_out;
    logic [15:0]  b_rd;
    logic         b_pend, b_done;

    coeff_bank_ctrl #(.COEFF_W(16), .TAPS(64), .BANDS(8), .SYNC_COMMIT(1)) u_sync (
        .clk(clk), .rst(rst_n), .clk_enable(ce), .current_count(cnt),
        .write_enable(we), .write_band(wb), .write_address(wa), .coeffs_in(din),
        .commit_req(req), .commit_pending(a_pend), .commit_done(a_done),
        .rd_band(rdb), .rd_address(rda), .rd_data(a_rd), .coeffs_out(a_out)
    );

    coeff_bank_ctrl #(.COEFF_W(16), .TAPS(8), .BANDS(6), .SYNC_COMMIT(0)) u_imm (
        .clk(clk), .rst(rst_n), .clk_enable(ce), .current_count(cnt[2:0]),
        .write_enable(we), .write_band(wb), .write_address(wa[2:0]), .coeffs_in(din),
        .commit_req(req), .commit_pending(b_pend), .commit_done(b_done),
        .rd_band(rdb), .rd_address(rda[2:0]), .rd_data(b_rd), .coeffs_out(b_out)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: index 0 = frame-synchronous instance, 1 = immediate instance.
    logic [15:0] stg   [2][8][64];
    logic [15:0] shd   [2][8][64];
    logic [15:0] eout  [2][8];
    logic [15:0] erd   [2];
    logic        pend  [2];
    logic        edone [2];

    logic [15:0] seen [64][8];
    int          ndone;
    logic [15:0] pre;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 8; b++) begin
                for (int t = 0; t < 64; t++) begin
                    stg[d][b][t] = '0;
                    shd[d][b][t] = '0;
                end
                eout[d][b] = '0;
            end
            erd[d]   = '0;
            pend[d]  = 1'b0;
            edone[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int  tp, bn, c, a, ra, rb, wbi;
        bit  fire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            tp  = (d == 0) ? 64 : 8;
            bn  = (d == 0) ? 8 : 6;
            c   = int'(cnt) % tp;
            a   = int'(wa) % tp;
            ra  = int'(rda) % tp;
            rb  = int'(rdb);
            wbi = int'(wb);
            fire = pend[d] && ((d == 1) || (ce && c == tp - 1));
            if (ce) begin
                for (int b = 0; b < bn; b++) eout[d][b] = shd[d][b][c];
            end
            erd[d] = (rb < bn) ? stg[d][rb][ra] : 16'h0000;
            if (fire) begin
                for (int b = 0; b < bn; b++)
                    for (int t = 0; t < tp; t++) shd[d][b][t] = stg[d][b][t];
            end
            if (ce && we && wbi < bn) stg[d][wbi][a] = din;
            edone[d] = fire;
            pend[d]  = req || (pend[d] && !fire);
        end
    endtask

    task automatic check_all(input string ph);
        for (int b = 0; b < 8; b++)
            chk($sformatf("%s A.out%0d", ph, b), 32'(a_out[b*16 +: 16]), 32'(eout[0][b]));
        for (int b = 0; b < 6; b++)
            chk($sformatf("%s B.out%0d", ph, b), 32'(b_out[b*16 +: 16]), 32'(eout[1][b]));
        chk({ph, " A.rd"},   32'(a_rd),   32'(erd[0]));
        chk({ph, " B.rd"},   32'(b_rd),   32'(erd[1]));
        chk({ph, " A.pend"}, 32'(a_pend), 32'(pend[0]));
        chk({ph, " B.pend"}, 32'(b_pend), 32'(pend[1]));
        chk({ph, " A.done"}, 32'(a_done), 32'(edone[0]));
        chk({ph, " B.done"}, 32'(b_done), 32'(edone[1]));
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic fill(input logic [15:0] val);
        ce = 1'b1; we = 1'b1; req = 1'b0; din = val;
        for (int b = 0; b < 8; b++) begin
            for (int t = 0; t < 64; t++) begin
                wb = 3'(b); wa = 6'(t); cnt = 6'(t);
                cyc("fill");
            end
        end
        we = 1'b0;
        $display("fill staging with %h", val);
    endtask

    // One enabled frame of counts 0..63; records band outputs per count and sync-commit pulses.
    task automatic frame(input logic [63:0] req_mask, input int wr_at, input logic [15:0] wval);
        ndone = 0;
        for (int c = 0; c < 64; c++) begin
            ce = 1'b1; cnt = 6'(c); req = req_mask[c];
            we = (c == wr_at); wb = 3'd0; wa = 6'd5; din = wval;
            cyc("frame");
            for (int b = 0; b < 8; b++) seen[c][b] = a_out[b*16 +: 16];
            if (a_done) ndone++;
        end
        req = 1'b0; we = 1'b0;
        $display("frame req_mask=%h wr_at=%0d commits=%0d", req_mask, wr_at, ndone);
    endtask

    initial begin
        // Reset with write traffic active
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; we = 1'b1; wb = 3'($urandom); wa = 6'($urandom); din = 16'($urandom);
            req = 1'b1; rdb = wb; rda = wa;
            cyc("rst_hold");
        end
        chk("rst out zero", 32'(|a_out), 32'd0);
        chk("rst rd zero", 32'(a_rd), 32'd0);
        rst_n = 1'b1; req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            we = 1'($urandom_range(1)); wb = 3'($urandom); wa = 6'($urandom); din = 16'($urandom);
            cnt = 6'($urandom); rdb = 3'($urandom); rda = 6'($urandom);
            cyc("post_rst");
        end
        chk("post_rst A.out zero", 32'(|a_out), 32'd0);
        chk("post_rst B.out zero", 32'(|b_out), 32'd0);

        // Write then read back two edges later
        we = 1'b1; wb = 3'd3; wa = 6'd17; din = 16'h8001; rdb = 3'd3; rda = 6'd17; cnt = 6'd0;
        cyc("wr");
        we = 1'b0;
        cyc("rd");
        chk("readback A", 32'(a_rd), 32'h8001);
        chk("readback B", 32'(b_rd), 32'h8001);
        chk("no commit A.out", 32'(|a_out), 32'd0);

        // Synchronous commit boundary
        fill(16'h0100);
        frame(64'h1, -1, 16'h0);
        fill(16'h0200);
        frame(64'h1 << 10, -1, 16'h0);
        for (int c = 11; c < 64; c++)
            for (int b = 0; b < 8; b++)
                chk($sformatf("old frame c%0d b%0d", c, b), 32'(seen[c][b]), 32'h0100);
        chk("boundary commit count", 32'(ndone), 32'd1);
        frame(64'h0, -1, 16'h0);
        for (int c = 0; c < 64; c++)
            for (int b = 0; b < 8; b++)
                chk($sformatf("new frame c%0d b%0d", c, b), 32'(seen[c][b]), 32'h0200);

        // Write colliding with the commit edge
        frame(64'h1 << 3, 63, 16'h7FFF);
        frame(64'h1, -1, 16'h0);
        chk("collision old tap5", 32'(seen[5][0]), 32'h0200);
        chk("second commit count", 32'(ndone), 32'd1);
        frame(64'h0, -1, 16'h0);
        chk("collision new tap5", 32'(seen[5][0]), 32'h7FFF);
        chk("collision tap6", 32'(seen[6][0]), 32'h0200);

        // Invalid band write (band 6 exists only in the 8-band instance)
        ce = 1'b1; we = 1'b1; wb = 3'd6; wa = 6'd5; din = 16'h1234; rdb = 3'd6; rda = 6'd5;
        cyc("bad_band_wr");
        we = 1'b0;
        cyc("bad_band_rd");
        chk("band6 A rd", 32'(a_rd), 32'h1234);
        chk("band6 B rd", 32'(b_rd), 32'h0000);
        rdb = 3'd0;
        cyc("band0_rd");
        chk("band0 B unchanged", 32'(b_rd), 32'h7FFF);

        // Three requests before one boundary merge into one commit
        frame((64'h1 << 2) | (64'h1 << 9) | (64'h1 << 30), -1, 16'h0);
        chk("merged commit count", 32'(ndone), 32'd1);

        // Immediate commit while the datapath is stalled
        ce = 1'b1; we = 1'b1; wb = 3'd2; wa = 6'd3; din = 16'hABCD; cnt = 6'd0;
        cyc("imm_wr");
        we = 1'b0;
        pre = b_out[2*16 +: 16];
        ce = 1'b0; req = 1'b1;
        cyc("imm_req");
        chk("imm pending", 32'(b_pend), 32'd1);
        chk("imm no done yet", 32'(b_done), 32'd0);
        req = 1'b0;
        cyc("imm_commit");
        chk("imm done", 32'(b_done), 32'd1);
        chk("imm pending clear", 32'(b_pend), 32'd0);
        chk("imm out held", 32'(b_out[2*16 +: 16]), 32'(pre));
        cyc("imm_after");
        chk("imm done one cycle", 32'(b_done), 32'd0);
        ce = 1'b1; cnt = 6'd3;
        cyc("imm_enable");
        chk("imm new coeff", 32'(b_out[2*16 +: 16]), 32'hABCD);

        // Randomized traffic, with an asynchronous reset landing while a commit is pending
        for (int i = 0; i < 1500; i++) begin
            ce  = ($urandom_range(3) != 0);
            we  = 1'($urandom_range(1));
            wb  = 3'($urandom); wa = 6'($urandom); din = 16'($urandom);
            req = ($urandom_range(31) == 0);
            rdb = 3'($urandom); rda = 6'($urandom);
            if (ce) cnt = cnt + 6'd1;
            cyc("random");
            if (i == 700) begin
                req = 1'b1; ce = 1'b1; cnt = 6'd20;
                cyc("pre_rst_req");
                req = 1'b0;
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_all("mid_rst");
                chk("mid_rst A.pend", 32'(a_pend), 32'd0);
                cyc("mid_rst_hold");
                cyc("mid_rst_hold");
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
